valu_wb_ctrl: RTL and testbench

VALU_WB_CTRL -- requirements
Module: valu_wb_ctrl

---
 rtl/valu_pkg.sv | 37 +++
 rtl/valu_wb_fifo.sv | 62 ++++++
 rtl/valu_wb_ctrl.sv | 132 +++++++++++++
 tb/tb_valu_wb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU writeback controller.
//   - valu_op_e   : opcode enumeration (Fadd = 0 .. Vmin = 18); 19..31 are illegal
//   - valu_wb_t   : one writeback record {dst, is_vec, vdata, sdata}
//   - valu_is_vec : vector/scalar classification of an opcode
//   - valu_is_legal : opcode lies inside the defined range
//   - default LAT / FIFO_DEPTH constants
package valu_pkg;

  localparam int VALU_LAT_DEF        = 8;
  localparam int VALU_FIFO_DEPTH_DEF = 4;

  typedef enum logic [4:0] {
    Fadd  = 5'd0,  Fsub  = 5'd1,  Fmul  = 5'd2,
    Vadd  = 5'd3,  Vsub  = 5'd4,  Vmul  = 5'd5,
    Vdot  = 5'd6,  Vsum  = 5'd7,  Vmaxr = 5'd8,  Vminr = 5'd9,
    Vand  = 5'd10, Vor   = 5'd11, Vxor  = 5'd12, Vshl  = 5'd13,
    Vshr  = 5'd14, Vabs  = 5'd15, Vneg  = 5'd16, Vmax  = 5'd17,
    Vmin  = 5'd18
  } valu_op_e;

  typedef struct packed {
    logic [4:0]       dst;
    logic             is_vec;
    logic [3:0][31:0] vdata;
    logic [31:0]      sdata;
  } valu_wb_t;

  // Reductions (Vdot..Vminr) and the F* ops write a scalar register.
  function automatic logic valu_is_vec(input logic [4:0] op);
    return ((op >= Vadd) && (op <= Vmul)) || ((op >= Vand) && (op <= Vmin));
  endfunction

  function automatic logic valu_is_legal(input logic [4:0] op);
    return op <= Vmin;
  endfunction

endpackage

// File: rtl/valu_wb_fifo.sv
// Synchronous result FIFO for the writeback controller.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (control only)
//   push_i, wdata_i   : write a record (caller guarantees !full_o or pop_i)
//   pop_i, rdata_o    : remove the head record; rdata_o always shows the head
//   full_o, empty_o   : occupancy flags
//   count_o           : occupancy, log2(DEPTH)+1 bits
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module valu_wb_fifo
  import valu_pkg::*;
#(
  parameter int DEPTH = VALU_FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  valu_wb_t                 wdata_i,
  output valu_wb_t                 rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  valu_wb_t       mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/valu_wb_ctrl.sv
// Vector ALU issue/writeback controller.
// Tracks a {valid, dst, is_vec} tag alongside each op through the LAT-deep
// ALU pipeline, buffers completed results in valu_wb_fifo and retires them
// in issue order over a valid/ready writeback port. A full buffer with a
// valid tail tag freezes both the tag pipe and the ALU (alu_en = 0).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   in_valid/in_ready, in_op/imm/dst : op issue handshake and fields
//   alu_en, alu_op, alu_imm          : ALU enable and pass-through controls
//   alu_vout, alu_rout               : ALU results for the tail op
//   wb_valid/wb_ready, wb_dst        : writeback handshake and destination
//   wb_is_vec, wb_vdata, wb_sdata    : writeback payload (zero when idle)
//   busy                             : tag in flight or result buffered
//   illegal_op                       : sticky, set by opcodes 19..31
// Build option: define VALU_WB_BYPASS_EN to forward a tail result straight
// to wb_* when the buffer is empty and wb_ready is high (latency LAT
// instead of LAT+1).
module valu_wb_ctrl
  import valu_pkg::*;
#(
  parameter int LAT        = VALU_LAT_DEF,
  parameter int FIFO_DEPTH = VALU_FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [7:0]            in_imm,
  input  logic [4:0]            in_dst,
  output logic                  alu_en,
  output logic [4:0]            alu_op,
  output logic [7:0]            alu_imm,
  input  logic [3:0][31:0]      alu_vout,
  input  logic [31:0]           alu_rout,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_dst,
  output logic                  wb_is_vec,
  output logic [3:0][31:0]      wb_vdata,
  output logic [31:0]           wb_sdata,
  output logic                  busy,
  output logic                  illegal_op
);
  logic [LAT-1:0]   tag_vld_q, tag_vld_d;
  logic [4:0]       tag_dst_q [LAT];
  logic [LAT-1:0]   tag_vec_q;
  logic             illegal_q, illegal_d;

  logic             accept, op_legal, tail_vld, bypass;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty, wb_fire;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  valu_wb_t         tail_res, head_res, wb_res;

  assign alu_op   = in_op;
  assign alu_imm  = in_imm;
  assign in_ready = alu_en;
  assign accept   = in_valid && in_ready;
  assign op_legal = valu_is_legal(in_op);
  assign tail_vld = tag_vld_q[LAT-1];
  assign tail_res = {tag_dst_q[LAT-1], tag_vec_q[LAT-1], alu_vout, alu_rout};

`ifdef VALU_WB_BYPASS_EN
  // Only taken with an empty buffer, so ordering is preserved.
  assign bypass = tail_vld && fifo_empty && wb_ready;
`else
  assign bypass = 1'b0;
`endif

  assign wb_valid  = !fifo_empty || bypass;
  assign wb_fire   = wb_valid && wb_ready;
  assign fifo_pop  = !fifo_empty && wb_ready;
  // A pop in the same cycle frees the slot the tail result needs.
  assign alu_en    = !(tail_vld && fifo_full && !wb_fire);
  assign fifo_push = tail_vld && alu_en && !bypass;

  assign wb_res    = !fifo_empty ? head_res : (bypass ? tail_res : '0);
  assign wb_dst    = wb_res.dst;
  assign wb_is_vec = wb_res.is_vec;
  assign wb_vdata  = wb_res.vdata;
  assign wb_sdata  = wb_res.sdata;

  assign busy       = (|tag_vld_q) || (fifo_cnt != '0);
  assign illegal_op = illegal_q;

  // Illegal opcodes still occupy a slot in the pipe but never write back.
  always_comb begin
    tag_vld_d = tag_vld_q;
    if (alu_en) begin
      for (int i = LAT - 1; i > 0; i--) tag_vld_d[i] = tag_vld_q[i-1];
      tag_vld_d[0] = accept && op_legal;
    end
    illegal_d = illegal_q || (accept && !op_legal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      tag_vld_q <= tag_vld_d;
      illegal_q <= illegal_d;
    end
  end

  // Tag payload; meaningful only where the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (alu_en) begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_dst_q[i] <= tag_dst_q[i-1];
        tag_vec_q[i] <= tag_vec_q[i-1];
      end
      tag_dst_q[0] <= in_dst;
      tag_vec_q[0] <= valu_is_vec(in_op);
    end
  end

  valu_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (tail_res),
    .rdata_o (head_res),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule

// File: tb/tb_valu_wb_ctrl.sv
module tb_valu_wb_ctrl;
  localparam int LAT = 8;
  localparam int FD  = 4;
`ifdef VALU_WB_BYPASS_EN
  localparam int EXP_LAT = LAT;
`else
  localparam int EXP_LAT = LAT + 1;
`endif

  typedef struct packed {
    logic [4:0]       dst;
    logic             vec;
    logic [3:0][31:0] v;
    logic [31:0]      s;
  } res_t;

  logic             clk, rst_n;
  logic             in_valid, in_ready;
  logic [4:0]       in_op, in_dst;
  logic [7:0]       in_imm;
  logic             alu_en;
  logic [4:0]       alu_op;
  logic [7:0]       alu_imm;
  logic [3:0][31:0] alu_vout;
  logic [31:0]      alu_rout;
  logic             wb_valid, wb_ready;
  logic [4:0]       wb_dst;
  logic             wb_is_vec;
  logic [3:0][31:0] wb_vdata;
  logic [31:0]      wb_sdata;
  logic             busy, illegal_op;

  int checks = 0;
  int errors = 0;

  // Reference model state: ops accepted (in order), results retired, and the
  // ALU result of each op keyed by the enabled-cycle index at which it issued.
  res_t             exp_q[$];
  res_t             act_q[$];
  logic [159:0]     alu_data [int];
  int               en_cnt = 0;
  int               cyc = 0;
  bit               seen_illegal = 0;
  logic [159:0]     mon_d;

  valu_wb_ctrl #(.LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_dst(in_dst),
    .alu_en(alu_en), .alu_op(alu_op), .alu_imm(alu_imm),
    .alu_vout(alu_vout), .alu_rout(alu_rout),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
    .wb_is_vec(wb_is_vec), .wb_vdata(wb_vdata), .wb_sdata(wb_sdata),
    .busy(busy), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic bit model_vec(input logic [4:0] op);
    return (op inside {[5'd3:5'd5], [5'd10:5'd18]});
  endfunction

  // Observer: records issues and retirements that happen at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        mon_d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        alu_data[en_cnt] = mon_d;
        if (in_op <= 5'd18)
          exp_q.push_back('{dst: in_dst, vec: model_vec(in_op), v: mon_d[159:32], s: mon_d[31:0]});
        else
          seen_illegal = 1'b1;
      end
      if (wb_valid && wb_ready)
        act_q.push_back('{dst: wb_dst, vec: wb_is_vec, v: wb_vdata, s: wb_sdata});
      if (alu_en) en_cnt++;
    end
  end

  // ALU model: the result of the op issued LAT enabled cycles ago, else noise.
  always @(posedge clk) begin
    #1;
    if (alu_data.exists(en_cnt - LAT)) {alu_vout, alu_rout} = alu_data[en_cnt - LAT];
    else {alu_vout, alu_rout} = {$urandom, $urandom, $urandom, $urandom, $urandom};
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    exp_q.delete(); act_q.delete(); alu_data.delete(); seen_illegal = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
    checks++; if (alu_en !== 1'b1) begin errors++; $display("FAIL reset_alu_en got %0b want 1", alu_en); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %0b want 0", illegal_op); end
    checks++; if ({wb_dst, wb_is_vec, wb_vdata, wb_sdata} !== '0) begin
      errors++; $display("FAIL reset_payload got dst=%0d vec=%0b want all zero", wb_dst, wb_is_vec);
    end
    in_op = 5'd13; in_imm = 8'hA5; #1;
    checks++; if (alu_op !== 5'd13 || alu_imm !== 8'hA5) begin
      errors++; $display("FAIL passthru got op=%0d imm=%h want 13/a5", alu_op, alu_imm);
    end
  endtask

  task automatic test_latency();
    int found;
    do_reset();
    @(posedge clk); #1;
    wb_ready = 1'b1; in_valid = 1'b1; in_op = 5'd3; in_dst = 5'd7; in_imm = 8'($urandom);
    found = -1;
    @(negedge clk);
    for (int k = 1; k <= 40 && found < 0; k++) begin
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      if (wb_valid) found = k;
    end
    checks++; if (found != EXP_LAT) begin errors++; $display("FAIL vadd_latency got %0d want %0d", found, EXP_LAT); end
    checks++;
    if (exp_q.size() != 1) begin
      errors++; $display("FAIL vadd_model got %0d entries want 1", exp_q.size());
    end else if (wb_dst !== 5'd7 || wb_is_vec !== 1'b1 || wb_vdata !== exp_q[0].v) begin
      errors++; $display("FAIL vadd_payload got dst=%0d vec=%0b v=%h want 7/1/%h", wb_dst, wb_is_vec, wb_vdata, exp_q[0].v);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vadd_idle got busy=%0b want 0", busy); end
  endtask

  task automatic test_scalar();
    int found;
    do_reset();
    @(posedge clk); #1;
    wb_ready = 1'b1; in_valid = 1'b1; in_op = 5'd6; in_dst = 5'd2;
    found = -1;
    @(negedge clk);
    for (int k = 1; k <= 40 && found < 0; k++) begin
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      if (wb_valid) found = k;
    end
    checks++; if (found != EXP_LAT) begin errors++; $display("FAIL vdot_latency got %0d want %0d", found, EXP_LAT); end
    checks++;
    if (exp_q.size() != 1) begin
      errors++; $display("FAIL vdot_model got %0d entries want 1", exp_q.size());
    end else if (wb_dst !== 5'd2 || wb_is_vec !== 1'b0 || wb_sdata !== exp_q[0].s) begin
      errors++; $display("FAIL vdot_payload got dst=%0d vec=%0b s=%h want 2/0/%h", wb_dst, wb_is_vec, wb_sdata, exp_q[0].s);
    end
  endtask

  task automatic test_back_to_back();
    int c0, stall_c, guard;
    do_reset();
    c0 = -1; stall_c = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = 5'($urandom_range(0, 18)); in_dst = 5'(i); in_imm = 8'($urandom);
      if (i == 0) c0 = cyc;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    end
    @(posedge clk); #1; in_valid = 1'b0;
    for (int k = 0; k < 60 && stall_c < 0; k++) begin
      @(negedge clk);
      if (!alu_en) stall_c = cyc;
    end
    checks++; if (stall_c != c0 + 4 + LAT) begin errors++; $display("FAIL b2b_stall_cycle got %0d want %0d", stall_c - c0, 4 + LAT); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready got %0b want 0", in_ready); end
    repeat (3) @(negedge clk);
    checks++; if (alu_en !== 1'b0 || wb_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_hold got en=%0b wbv=%0b busy=%0b want 0/1/1", alu_en, wb_valid, busy);
    end
    checks++; if (exp_q.size() != 12 || act_q.size() != 0) begin
      errors++; $display("FAIL b2b_accepted got %0d/%0d want 12/0", exp_q.size(), act_q.size());
    end
  endtask

  // Continues from the frozen, full state left by test_back_to_back.
  task automatic test_full_pop_push();
    int guard;
    @(posedge clk); #1; wb_ready = 1'b1; #1;
    checks++; if (alu_en !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fullpp_en got en=%0b rdy=%0b want 1/1", alu_en, in_ready);
    end
    @(posedge clk); #1; wb_ready = 1'b0; #1;
    checks++; if (alu_en !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL fullpp_still_full got en=%0b wbv=%0b want 0/1", alu_en, wb_valid);
    end
    checks++; if (exp_q.size() < 2 || wb_dst !== exp_q[1].dst) begin
      errors++; $display("FAIL fullpp_head got dst=%0d want 1", wb_dst);
    end
    @(posedge clk); #1; wb_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    checks++; if (busy) begin errors++; $display("FAIL b2b_drain got busy=1 want 0"); end
    checks++; if (act_q.size() != 12 || exp_q.size() != 12) begin
      errors++; $display("FAIL b2b_count got %0d retired want 12", act_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_order[%0d] got dst=%0d vec=%0b want dst=%0d vec=%0b", i, act_q[i].dst, act_q[i].vec, exp_q[i].dst, exp_q[i].vec);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    @(posedge clk); #1;
    wb_ready = 1'b1; in_valid = 1'b1; in_op = 5'd25; in_dst = 5'd3;
    @(negedge clk);
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_early got %0b want 0", illegal_op); end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_set got %0b want 1", illegal_op); end
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL illegal_wb cycle %0d got wb_valid=1 want 0", k); end
    end
    checks++; if (busy !== 1'b0 || illegal_op !== 1'b1 || act_q.size() != 0) begin
      errors++; $display("FAIL illegal_drain got busy=%0b ill=%0b ret=%0d want 0/1/0", busy, illegal_op, act_q.size());
    end
    do_reset();
    @(negedge clk);
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_clear got %0b want 0", illegal_op); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      wb_ready = 1'b1; in_valid = 1'b1; in_op = 5'($urandom_range(0, 18)); in_dst = 5'(20 + i);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %0b want 1", busy); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate got busy=%0b wbv=%0b want 0/0", busy, wb_valid);
    end
    exp_q.delete(); act_q.delete(); alu_data.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (LAT + 6) @(negedge clk);
    checks++; if (act_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_stale got %0d retired busy=%0b want 0/0", act_q.size(), busy);
    end
  endtask

  task automatic test_random();
    bit   hold;
    logic [166:0] prev, cur;
    int   guard;
    do_reset();
    hold = 1'b0; prev = '0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      in_valid = ($urandom % 3) != 0;
      in_op    = (($urandom % 8) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
      in_dst   = 5'($urandom);
      in_imm   = 8'($urandom);
      if (n >= 100 && n < 180) wb_ready = ($urandom % 10) == 0;
      else                     wb_ready = ($urandom % 4) != 0;
      @(negedge clk);
      cur = {wb_valid, wb_dst, wb_is_vec, wb_vdata, wb_sdata};
      if (hold) begin
        checks++;
        if (cur !== prev) begin errors++; $display("FAIL rand_hold cycle %0d got dst=%0d want dst=%0d", n, wb_dst, prev[165:161]); end
      end
      hold = wb_valid && !wb_ready;
      prev = cur;
    end
    @(posedge clk); #1; in_valid = 1'b0; wb_ready = 1'b1;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin @(negedge clk); guard++; end
    checks++; if (busy) begin errors++; $display("FAIL rand_drain got busy=1 want 0"); end
    checks++; if (act_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d retired want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (act_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_order[%0d] got dst=%0d s=%h want dst=%0d s=%h", i, act_q[i].dst, act_q[i].s, exp_q[i].dst, exp_q[i].s);
      end
    end
    checks++; if (illegal_op !== seen_illegal) begin
      errors++; $display("FAIL rand_illegal got %0b want %0b", illegal_op, seen_illegal);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_dst = '0; in_imm = '0; wb_ready = 1'b0;
    alu_vout = '0; alu_rout = '0;
    test_reset();
    test_latency();
    test_scalar();
    test_back_to_back();
    test_full_pop_push();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
